// File: rtl/luma_ds_pkg.sv
// Shared constants and the RGB565-to-luma helper for the OV7670 luma downsampler.
package luma_ds_pkg;
  localparam int unsigned Y_WR   = 77;
  localparam int unsigned Y_WG   = 150;
  localparam int unsigned Y_WB   = 29;
  localparam int unsigned SHIFT  = 2;
  localparam int unsigned LAT    = 4;
  localparam int unsigned HSUM_W = 10;
  localparam int unsigned ACC_W  = 12;

  // Channels are widened by bit replication so full-scale inputs map to 255.
  function automatic logic [7:0] rgb565_to_y(input logic [4:0] r5, input logic [5:0] g6,
                                             input logic [4:0] b5);
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    r8  = {r5, r5[4:2]};
    g8  = {g6, g6[5:4]};
    b8  = {b5, b5[4:2]};
    sum = 16'(Y_WR) * 16'(r8) + 16'(Y_WG) * 16'(g8) + 16'(Y_WB) * 16'(b8);
    return sum[15:8];
  endfunction
endpackage

// File: rtl/line_accum_ram.sv
// Per-column vertical accumulator storage: simple dual-port, registered read.
module line_accum_ram #(
  parameter int DEPTH = 160,
  parameter int WIDTH = 12,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/luma_downsampler.sv
// OV7670 RGB565 byte stream to 8-bit luma, 4x4 box-filtered, one output pixel per strobe.
module luma_downsampler
  import luma_ds_pkg::*;
#(
  parameter int IN_W   = 640,
  parameter int IN_H   = 480,
  parameter int OUT_W  = 160,
  parameter int OUT_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              pix_valid,
  output logic [7:0]        pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              frame_start,
  output logic              frame_done,
  output logic              frame_abort
);
  localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int X_W   = $clog2(IN_W + 1);
  localparam int Y_W   = $clog2(IN_H + 1);
  localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W + 1)'(OUT_W * OUT_H);
  localparam logic [ADDR_W:0] PIX_LAST  = (ADDR_W + 1)'(OUT_W * OUT_H - 1);

  logic              vsync_q, vsync_d, href_q, href_d, phase_q, phase_d;
  logic [7:0]        byte0_q, byte0_d;
  logic [X_W-1:0]    in_x_q, in_x_d;
  logic [Y_W-1:0]    in_y_q, in_y_d;
  logic [LAT-1:0]    vld_q, vld_d;
  logic [4:0]        r5_q, r5_d, b5_q, b5_d;
  logic [5:0]        g6_q, g6_d;
  logic [7:0]        y2_q, y2_d;
  logic [1:0]        xlo1_q, xlo1_d, xlo2_q, xlo2_d;
  logic [1:0]        row1_q, row1_d, row2_q, row2_d, row3_q, row3_d, row4_q, row4_d;
  logic [COL_W-1:0]  col1_q, col1_d, col2_q, col2_d, col3_q, col3_d, col4_q, col4_d;
  logic [HSUM_W-1:0] hacc_q, hacc_d, hsum3_q, hsum3_d, hsum4_q, hsum4_d;
  logic [ADDR_W:0]   out_cnt_q, out_cnt_d;
  logic              pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic              frame_done_q, frame_done_d, frame_abort_q, frame_abort_d;
  logic [7:0]        pix_data_q, pix_data_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;

  logic              href_eff, vs_rise, href_fall, px_done, px_keep, emit, ram_we;
  logic [ACC_W-1:0]  ram_rdata, acc_sum;

  // Bytes arriving while vsync is high are treated as blanking.
  assign href_eff  = cam_href & ~cam_vsync;
  assign vs_rise   = cam_vsync & ~vsync_q;
  assign href_fall = href_q & ~href_eff;
  assign px_done   = href_eff & phase_q;
  assign px_keep   = px_done && (in_x_q < X_W'(IN_W)) && (in_y_q < Y_W'(IN_H));
  assign acc_sum   = ((row4_q == 2'd0) ? '0 : ram_rdata) + ACC_W'(hsum4_q);
  assign ram_we    = vld_q[LAT-1] && (row4_q != 2'd3) && !vs_rise;
  assign emit      = vld_q[LAT-1] && (row4_q == 2'd3) && (out_cnt_q < PIX_TOTAL) && !vs_rise;

  line_accum_ram #(.DEPTH(OUT_W), .WIDTH(ACC_W), .AW(COL_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (col4_q),
    .wdata (acc_sum),
    .raddr (col3_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    vsync_d = cam_vsync;
    href_d  = href_eff;
    phase_d = href_eff ? ~phase_q : 1'b0;
    byte0_d = (href_eff && !phase_q) ? cam_data : byte0_q;
    in_x_d  = in_x_q;
    in_y_d  = in_y_q;
    if (vs_rise) begin
      in_x_d = '0;
      in_y_d = '0;
    end else if (href_fall) begin
      in_x_d = '0;
      if (in_x_q != '0 && in_y_q < Y_W'(IN_H)) in_y_d = in_y_q + 1'b1;
    end else if (px_keep) begin
      in_x_d = in_x_q + 1'b1;
    end

    r5_d = r5_q;  g6_d = g6_q;  b5_d = b5_q;
    xlo1_d = xlo1_q;  row1_d = row1_q;  col1_d = col1_q;
    if (px_keep) begin
      r5_d   = byte0_q[7:3];
      g6_d   = {byte0_q[2:0], cam_data[7:5]};
      b5_d   = cam_data[4:0];
      xlo1_d = in_x_q[1:0];
      row1_d = in_y_q[1:0];
      col1_d = COL_W'(in_x_q >> SHIFT);
    end

    y2_d = y2_q;  xlo2_d = xlo2_q;  row2_d = row2_q;  col2_d = col2_q;
    if (vld_q[0]) begin
      y2_d   = rgb565_to_y(r5_q, g6_q, b5_q);
      xlo2_d = xlo1_q;
      row2_d = row1_q;
      col2_d = col1_q;
    end

    // A new column starts on every in_x[1:0]==0, so partial columns never leak forward.
    hacc_d = hacc_q;  hsum3_d = hsum3_q;  row3_d = row3_q;  col3_d = col3_q;
    if (vld_q[1]) begin
      hacc_d  = (xlo2_q == 2'd0) ? HSUM_W'(y2_q) : hacc_q + HSUM_W'(y2_q);
      hsum3_d = hacc_d;
      row3_d  = row2_q;
      col3_d  = col2_q;
    end

    hsum4_d = hsum4_q;  row4_d = row4_q;  col4_d = col4_q;
    if (vld_q[2]) begin
      hsum4_d = hsum3_q;
      row4_d  = row3_q;
      col4_d  = col3_q;
    end

    vld_d    = '0;
    vld_d[0] = px_keep;
    vld_d[1] = vld_q[0];
    vld_d[2] = vld_q[1] && (xlo2_q == 2'd3);
    vld_d[3] = vld_q[2];
    if (vs_rise) vld_d = '0;

    pix_valid_d   = emit;
    frame_start_d = emit && (out_cnt_q == '0);
    frame_done_d  = emit && (out_cnt_q == PIX_LAST);
    frame_abort_d = vs_rise && (out_cnt_q != '0) && (out_cnt_q < PIX_TOTAL);
    pix_data_d    = emit ? acc_sum[ACC_W-1 -: 8] : pix_data_q;
    pix_addr_d    = emit ? out_cnt_q[ADDR_W-1:0] : pix_addr_q;
    out_cnt_d     = out_cnt_q;
    if (vs_rise) out_cnt_d = '0;
    else if (emit) out_cnt_d = out_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;  href_q <= 1'b0;  phase_q <= 1'b0;  byte0_q <= '0;
      in_x_q <= '0;  in_y_q <= '0;  vld_q <= '0;
      r5_q <= '0;  g6_q <= '0;  b5_q <= '0;  y2_q <= '0;
      xlo1_q <= '0;  xlo2_q <= '0;
      row1_q <= '0;  row2_q <= '0;  row3_q <= '0;  row4_q <= '0;
      col1_q <= '0;  col2_q <= '0;  col3_q <= '0;  col4_q <= '0;
      hacc_q <= '0;  hsum3_q <= '0;  hsum4_q <= '0;  out_cnt_q <= '0;
      pix_valid_q <= 1'b0;  frame_start_q <= 1'b0;  frame_done_q <= 1'b0;
      frame_abort_q <= 1'b0;  pix_data_q <= '0;  pix_addr_q <= '0;
    end else begin
      vsync_q <= vsync_d;  href_q <= href_d;  phase_q <= phase_d;  byte0_q <= byte0_d;
      in_x_q <= in_x_d;  in_y_q <= in_y_d;  vld_q <= vld_d;
      r5_q <= r5_d;  g6_q <= g6_d;  b5_q <= b5_d;  y2_q <= y2_d;
      xlo1_q <= xlo1_d;  xlo2_q <= xlo2_d;
      row1_q <= row1_d;  row2_q <= row2_d;  row3_q <= row3_d;  row4_q <= row4_d;
      col1_q <= col1_d;  col2_q <= col2_d;  col3_q <= col3_d;  col4_q <= col4_d;
      hacc_q <= hacc_d;  hsum3_q <= hsum3_d;  hsum4_q <= hsum4_d;  out_cnt_q <= out_cnt_d;
      pix_valid_q <= pix_valid_d;  frame_start_q <= frame_start_d;  frame_done_q <= frame_done_d;
      frame_abort_q <= frame_abort_d;  pix_data_q <= pix_data_d;  pix_addr_q <= pix_addr_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_addr    = pix_addr_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
endmodule

// File: tb/tb_luma_downsampler.sv
// Scoreboard bench for luma_downsampler on a reduced 16x12 -> 4x3 geometry.
module tb_luma_downsampler;
  localparam int IN_W = 16;
  localparam int IN_H = 12;
  localparam int OUT_W = 4;
  localparam int OUT_H = 3;
  localparam int ADDR_W = 15;
  localparam int EXP_LAT = 4;
  localparam int K_WHITE = 0, K_RED = 1, K_GREEN = 2, K_BLUE = 3;
  localparam int K_RAMP = 4, K_COLS = 5, K_STRIPE = 6;

  typedef struct {
    logic [7:0]        data;
    logic [ADDR_W-1:0] addr;
    logic              start;
    logic              done;
    int                samp;
  } exp_t;

  logic clk, rst_n, cam_vsync, cam_href;
  logic [7:0] cam_data;
  logic pix_valid, frame_start, frame_done, frame_abort;
  logic [7:0] pix_data;
  logic [ADDR_W-1:0] pix_addr;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_addr = 0;
  int exp_abort = 0;
  int abort_seen = 0;

  luma_downsampler #(
    .IN_W(IN_W), .IN_H(IN_H), .OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_addr    (pix_addr),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 60000) begin
      $display("[TB] FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand-computed luma of the 4x4 box for each pattern (and output column where it varies).
  function automatic logic [7:0] exp_val(int kind, int col);
    case (kind)
      K_WHITE:  return 8'd255;
      K_RED:    return 8'd76;
      K_GREEN:  return 8'd149;
      K_BLUE:   return 8'd28;
      K_RAMP:   return 8'd63;
      K_STRIPE: return 8'd127;
      default:
        case (col % 4)
          0: return 8'd255;
          1: return 8'd76;
          2: return 8'd149;
          default: return 8'd28;
        endcase
    endcase
  endfunction

  function automatic logic [15:0] pix565(int kind, int x, int y);
    case (kind)
      K_WHITE: return 16'hFFFF;
      K_RED:   return 16'hF800;
      K_GREEN: return 16'h07E0;
      K_BLUE:  return 16'h001F;
      K_RAMP:
        case (x % 4)
          0: return 16'h0000;
          1: return 16'h001F;
          2: return 16'hF800;
          default: return 16'h07E0;
        endcase
      K_COLS:
        case ((x / 4) % 4)
          0: return 16'hFFFF;
          1: return 16'hF800;
          2: return 16'h07E0;
          default: return 16'h001F;
        endcase
      default: return ((y % 4) < 2) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      cam_href = 1'b0;
      cam_data = 8'h00;
    end
  endtask

  task automatic send_pixel(int kind, int x, int y);
    logic [15:0] p;
    exp_t e;
    p = pix565(kind, x, y);
    @(negedge clk);
    cam_href = 1'b1;
    cam_data = p[15:8];
    @(negedge clk);
    cam_data = p[7:0];
    if ((x % 4) == 3 && (y % 4) == 3 && x < IN_W && y < IN_H) begin
      e.data  = exp_val(kind, x / 4);
      e.addr  = ADDR_W'(exp_addr);
      e.start = (exp_addr == 0);
      e.done  = (exp_addr == OUT_W * OUT_H - 1);
      e.samp  = cyc + 1;
      sb.push_back(e);
      exp_addr++;
    end
  endtask

  // Vsync pulse with stray href activity inside it, which must be ignored.
  task automatic vsync_pulse();
    if (exp_addr > 0 && exp_addr < OUT_W * OUT_H) exp_abort++;
    exp_addr = 0;
    @(negedge clk);
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    repeat (2) @(negedge clk);
    repeat (6) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = 8'hA5;
    end
    idle(4);
    cam_vsync = 1'b0;
    idle(4);
  endtask

  task automatic apply_frame(int kind, int nlines, int short_y, int short_len);
    vsync_pulse();
    for (int y = 0; y < nlines; y++) begin
      int len;
      len = (y == short_y) ? short_len : IN_W;
      for (int x = 0; x < len; x++) send_pixel(kind, x, y);
      idle(4);
    end
    idle(8);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    check_output("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic check_reset_outs(string name);
    check_output(name, {5'd0, pix_valid, pix_data, pix_addr, frame_start, frame_done, frame_abort}, 0);
  endtask

  // Monitor: pops one expectation per strobe, independent of the stimulus process.
  always @(negedge clk) begin
    exp_t e;
    if (frame_abort) abort_seen++;
    if (pix_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_pix: got addr %0d data %0d, expected no output", pix_addr, pix_data);
      end else begin
        e = sb.pop_front();
        check_output("pix_data", pix_data, e.data);
        check_output("pix_addr", pix_addr, e.addr);
        check_output("frame_start", frame_start, e.start);
        check_output("frame_done", frame_done, e.done);
        check_output("latency", cyc - e.samp, EXP_LAT);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outs("reset_outs_initial");
    rst_n = 1'b1;

    $display("[TB] uniform and ramp frames");
    apply_frame(K_WHITE, IN_H, -1, 0);   drain();
    apply_frame(K_RED, IN_H, -1, 0);     drain();
    apply_frame(K_GREEN, IN_H, -1, 0);   drain();
    apply_frame(K_BLUE, IN_H, -1, 0);    drain();
    apply_frame(K_RAMP, IN_H, -1, 0);    drain();
    apply_frame(K_COLS, IN_H, -1, 0);    drain();
    apply_frame(K_STRIPE, IN_H, -1, 0);  drain();
    check_output("abort_count_clean", abort_seen, exp_abort);

    $display("[TB] truncated frame then full frame");
    apply_frame(K_WHITE, 8, -1, 0);      drain();
    apply_frame(K_COLS, IN_H, -1, 0);    drain();
    check_output("abort_count_trunc", abort_seen, exp_abort);

    $display("[TB] short line frame then full frame");
    apply_frame(K_WHITE, IN_H, 3, 8);    drain();
    apply_frame(K_RAMP, IN_H, -1, 0);    drain();
    check_output("abort_count_short", abort_seen, exp_abort);

    $display("[TB] reset mid-line");
    vsync_pulse();
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < IN_W; x++) send_pixel(K_WHITE, x, y);
      idle(4);
    end
    for (int x = 0; x < 5; x++) send_pixel(K_WHITE, x, 2);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      cam_href = ~cam_href;
      check_reset_outs("reset_outs_midline");
    end
    cam_href = 1'b0;
    sb.delete();
    exp_addr = 0;
    rst_n = 1'b1;
    idle(4);
    apply_frame(K_WHITE, IN_H, -1, 0);   drain();
    check_output("abort_count_final", abort_seen, exp_abort);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
